// File: rtl/alu_branch_pkg.sv
// Shared types and encodings for the decode/execute core: write-back selectors,
// memory access widths, branch kinds, ALU operations and MIPS opcode/funct values.
package alu_branch_pkg;

   typedef enum logic [1:0] {WA_RD = 2'd0, WA_RT = 2'd1, WA_RA = 2'd2} wa_mode_e;
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0, SRC_NEXT_PC = 2'd1, SRC_DATA = 2'd2, SRC_RESULT = 2'd3
   } wr_src_e;
   typedef enum logic [2:0] {
      MEM_NONE = 3'd0, MEM_BYTE = 3'd1, MEM_HALF = 3'd2, MEM_WORD = 3'd3
   } mem_mode_e;
   typedef enum logic [3:0] {
      BR_NONE, BR_BEQ, BR_BNE, BR_BLEZ, BR_BGTZ, BR_BLTZ, BR_BGEZ,
      BR_J, BR_JAL, BR_JR, BR_JALR
   } branch_mode_e;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
      ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
   } alu_op_e;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20, OP_LH     = 6'h21, OP_LW   = 6'h23, OP_LBU  = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25, OP_SB     = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR   = 6'h08, F_JALR = 6'h09;
   localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;

endpackage

// File: rtl/alu_branch_control_if.sv
// Instruction/operand inputs and decode/execute results of the core, grouped as one bundle.
interface alu_branch_control_if;
   logic [31:0] instructionData;
   logic [31:0] rsValue;
   logic [31:0] rtValue;
   logic [31:0] pcAddress;
   logic        registerRead;
   logic        registerWrite;
   logic [1:0]  registerWriteAddressMode;
   logic [1:0]  registerWriteSource;
   logic [2:0]  readMode;
   logic [2:0]  writeMode;
   logic        unsignedLoad;
   logic [31:0] result;
   logic        outputZero;
   logic        outputPositive;
   logic        outputNegative;
   logic        shouldUseNewPC;
   logic [31:0] branchTo;

   modport slave (
      input  instructionData, rsValue, rtValue, pcAddress,
      output registerRead, registerWrite, registerWriteAddressMode, registerWriteSource,
             readMode, writeMode, unsignedLoad, result, outputZero, outputPositive,
             outputNegative, shouldUseNewPC, branchTo
   );
   modport master (
      output instructionData, rsValue, rtValue, pcAddress,
      input  registerRead, registerWrite, registerWriteAddressMode, registerWriteSource,
             readMode, writeMode, unsignedLoad, result, outputZero, outputPositive,
             outputNegative, shouldUseNewPC, branchTo
   );
endinterface

// File: rtl/alu_core.sv
// 32-bit ALU: arithmetic wraps silently, shifts act on b by shamt, flags describe the result.
module alu_core
   import alu_branch_pkg::*;
(
   input  alu_op_e     op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  shamt,
   output logic [31:0] result,
   output logic        zero,
   output logic        positive,
   output logic        negative
);
   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:   result = a + b;
         ALU_SUB:   result = a - b;
         ALU_AND:   result = a & b;
         ALU_OR:    result = a | b;
         ALU_XOR:   result = a ^ b;
         ALU_NOR:   result = ~(a | b);
         ALU_SLT:   result = {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU:  result = {31'd0, a < b};
         ALU_SLL:   result = b << shamt;
         ALU_SRL:   result = b >> shamt;
         ALU_SRA:   result = $signed(b) >>> shamt;
         ALU_PASSB: result = b;
         default:   result = '0;
      endcase
   end

   assign zero     = (result == 32'd0);
   assign negative = result[31];
   assign positive = !zero && !negative;
endmodule

// File: rtl/alu_branch_control.sv
// Single-cycle MIPS decode/execute: instruction decode, ALU, and branch/jump resolution,
// with every side-effecting output forced quiet while the registered reset gate is set.
module alu_branch_control
   import alu_branch_pkg::*;
(
   input logic                 clk,
   input logic                 rst,
   alu_branch_control_if.slave bus
);
   logic in_reset_q, in_reset_d;

   logic [31:0] instr, rs_val, rt_val, pc_plus4, imm_sext, imm_zext;
   logic [5:0]  opcode, funct;
   alu_op_e      alu_op;
   logic [31:0]  alu_b, alu_result;
   logic [4:0]   alu_shamt;
   logic         alu_zero, alu_pos, alu_neg;
   logic         reg_read, reg_write, unsigned_load, take;
   wa_mode_e     wa_mode;
   wr_src_e      wr_src;
   mem_mode_e    rd_mode, wr_mode;
   branch_mode_e br_mode;
   logic [31:0]  target;

   assign in_reset_d = 1'b0;
   always_ff @(posedge clk) begin
      if (!rst) in_reset_q <= 1'b1;
      else      in_reset_q <= in_reset_d;
   end

   assign instr    = bus.instructionData;
   assign rs_val   = bus.rsValue;
   assign rt_val   = bus.rtValue;
   assign opcode   = instr[31:26];
   assign funct    = instr[5:0];
   assign imm_sext = {{16{instr[15]}}, instr[15:0]};
   assign imm_zext = {16'd0, instr[15:0]};
   assign pc_plus4 = bus.pcAddress + 32'd4;

   always_comb begin
      alu_op = ALU_ADD;  alu_b = rt_val;  alu_shamt = instr[10:6];
      reg_read = 1'b0;   reg_write = 1'b0; unsigned_load = 1'b0;
      wa_mode = WA_RD;   wr_src = SRC_NONE;
      rd_mode = MEM_NONE; wr_mode = MEM_NONE; br_mode = BR_NONE;
      case (opcode)
         OP_RTYPE: begin
            reg_read = 1'b1; reg_write = 1'b1; wr_src = SRC_RESULT;
            case (funct)
               F_SLL:  alu_op = ALU_SLL;
               F_SRL:  alu_op = ALU_SRL;
               F_SRA:  alu_op = ALU_SRA;
               F_SLLV: begin alu_op = ALU_SLL; alu_shamt = rs_val[4:0]; end
               F_SRLV: begin alu_op = ALU_SRL; alu_shamt = rs_val[4:0]; end
               F_SRAV: begin alu_op = ALU_SRA; alu_shamt = rs_val[4:0]; end
               F_JR:   begin reg_write = 1'b0; wr_src = SRC_NONE; br_mode = BR_JR; end
               F_JALR: begin wr_src = SRC_NEXT_PC; br_mode = BR_JALR; end
               F_ADD, F_ADDU: alu_op = ALU_ADD;
               F_SUB, F_SUBU: alu_op = ALU_SUB;
               F_AND:  alu_op = ALU_AND;
               F_OR:   alu_op = ALU_OR;
               F_XOR:  alu_op = ALU_XOR;
               F_NOR:  alu_op = ALU_NOR;
               F_SLT:  alu_op = ALU_SLT;
               F_SLTU: alu_op = ALU_SLTU;
               default: begin reg_read = 1'b0; reg_write = 1'b0; wr_src = SRC_NONE; end
            endcase
         end
         // Conditional branches compare via rs - cmp so the ALU flags decide the outcome.
         OP_REGIMM: begin
            alu_op = ALU_SUB; alu_b = '0; reg_read = 1'b1;
            case (instr[20:16])
               5'd0:    br_mode = BR_BLTZ;
               5'd1:    br_mode = BR_BGEZ;
               default: reg_read = 1'b0;
            endcase
         end
         OP_BEQ:  begin alu_op = ALU_SUB; reg_read = 1'b1; br_mode = BR_BEQ; end
         OP_BNE:  begin alu_op = ALU_SUB; reg_read = 1'b1; br_mode = BR_BNE; end
         OP_BLEZ: begin alu_op = ALU_SUB; alu_b = '0; reg_read = 1'b1; br_mode = BR_BLEZ; end
         OP_BGTZ: begin alu_op = ALU_SUB; alu_b = '0; reg_read = 1'b1; br_mode = BR_BGTZ; end
         OP_J:    br_mode = BR_J;
         OP_JAL:  begin reg_write = 1'b1; wa_mode = WA_RA; wr_src = SRC_NEXT_PC; br_mode = BR_JAL; end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            reg_read = (opcode != OP_LUI); reg_write = 1'b1;
            wa_mode = WA_RT; wr_src = SRC_RESULT; alu_b = imm_sext;
            case (opcode)
               OP_SLTI:  alu_op = ALU_SLT;
               OP_SLTIU: alu_op = ALU_SLTU;
               OP_ANDI:  begin alu_op = ALU_AND; alu_b = imm_zext; end
               OP_ORI:   begin alu_op = ALU_OR;  alu_b = imm_zext; end
               OP_XORI:  begin alu_op = ALU_XOR; alu_b = imm_zext; end
               OP_LUI:   begin alu_op = ALU_PASSB; alu_b = {instr[15:0], 16'd0}; end
               default:  alu_op = ALU_ADD;
            endcase
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            reg_read = 1'b1; reg_write = 1'b1; wa_mode = WA_RT; wr_src = SRC_DATA;
            alu_b = imm_sext;
            unsigned_load = (opcode == OP_LBU) || (opcode == OP_LHU);
            case (opcode)
               OP_LB, OP_LBU: rd_mode = MEM_BYTE;
               OP_LH, OP_LHU: rd_mode = MEM_HALF;
               default:       rd_mode = MEM_WORD;
            endcase
         end
         OP_SB, OP_SH, OP_SW: begin
            reg_read = 1'b1; alu_b = imm_sext;
            case (opcode)
               OP_SB:   wr_mode = MEM_BYTE;
               OP_SH:   wr_mode = MEM_HALF;
               default: wr_mode = MEM_WORD;
            endcase
         end
         default: ;
      endcase
   end

   alu_core u_alu (
      .op(alu_op), .a(rs_val), .b(alu_b), .shamt(alu_shamt),
      .result(alu_result), .zero(alu_zero), .positive(alu_pos), .negative(alu_neg)
   );

   always_comb begin
      take   = 1'b0;
      target = pc_plus4 + {imm_sext[29:0], 2'b00};
      case (br_mode)
         BR_BEQ:  take = alu_zero;
         BR_BNE:  take = !alu_zero;
         BR_BLEZ: take = alu_zero || alu_neg;
         BR_BGTZ: take = alu_pos;
         BR_BLTZ: take = alu_neg;
         BR_BGEZ: take = !alu_neg;
         BR_J, BR_JAL: begin take = 1'b1; target = {pc_plus4[31:28], instr[25:0], 2'b00}; end
         BR_JR, BR_JALR: begin take = 1'b1; target = rs_val; end
         default: take = 1'b0;
      endcase
   end

   assign bus.registerRead             = in_reset_q ? 1'b0 : reg_read;
   assign bus.registerWrite            = in_reset_q ? 1'b0 : reg_write;
   assign bus.registerWriteAddressMode = wa_mode;
   assign bus.registerWriteSource      = wr_src;
   assign bus.readMode                 = in_reset_q ? MEM_NONE : rd_mode;
   assign bus.writeMode                = in_reset_q ? MEM_NONE : wr_mode;
   assign bus.unsignedLoad             = unsigned_load;
   assign bus.result                   = in_reset_q ? 32'd0 : alu_result;
   assign bus.outputZero               = alu_zero;
   assign bus.outputPositive           = alu_pos;
   assign bus.outputNegative           = alu_neg;
   assign bus.shouldUseNewPC           = in_reset_q ? 1'b0 : take;
   assign bus.branchTo                 = in_reset_q ? 32'd0 : target;
endmodule

// File: tb/tb_alu_branch_control.sv
// Bench for alu_branch_control: directed cases from the instruction set rules, reset gating,
// and a randomized back-to-back stream checked against an instruction-level reference model.
module tb_alu_branch_control;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;

   alu_branch_control_if bus ();
   alu_branch_control dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct packed {
      logic        w;
      logic [1:0]  wa;
      logic [1:0]  src;
      logic [2:0]  rm;
      logic [2:0]  wm;
      logic        ul;
      logic [31:0] res;
      logic        take;
      logic [31:0] tgt;
      logic        chk_res;
      logic        chk_wa;
      logic        chk_ul;
   } exp_t;

   logic [5:0] op_list [0:23] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                  6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                  6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
   logic [5:0] fn_list [0:17] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                                  6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h2B};

   function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs, rt, rd, sh);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction
   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction
   function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] t);
      return {op, t};
   endfunction

   // Instruction-level reference: what each MIPS instruction must do to the outputs.
   function automatic exp_t model(input logic [31:0] ins, rs, rt, pc);
      exp_t e;
      logic [5:0]  op, fn;
      logic [4:0]  sh;
      logic [31:0] simm, zimm, pc4;
      int          srs, srt, ssimm;
      bit          arith;
      e = '0;
      op = ins[31:26]; fn = ins[5:0]; sh = ins[10:6];
      simm = {{16{ins[15]}}, ins[15:0]}; zimm = {16'd0, ins[15:0]};
      pc4 = pc + 32'd4;
      srs = rs; srt = rt; ssimm = simm;
      case (op)
         6'h00: begin
            arith = 1'b1;
            case (fn)
               6'h00: e.res = rt << sh;
               6'h02: e.res = rt >> sh;
               6'h03: e.res = srt >>> sh;
               6'h04: e.res = rt << rs[4:0];
               6'h06: e.res = rt >> rs[4:0];
               6'h07: e.res = srt >>> rs[4:0];
               6'h08: begin arith = 1'b0; e.take = 1'b1; e.tgt = rs; end
               6'h09: begin
                  arith = 1'b0; e.w = 1'b1; e.chk_wa = 1'b1; e.wa = 2'd0; e.src = 2'd1;
                  e.take = 1'b1; e.tgt = rs;
               end
               6'h20, 6'h21: e.res = rs + rt;
               6'h22, 6'h23: e.res = rs - rt;
               6'h24: e.res = rs & rt;
               6'h25: e.res = rs | rt;
               6'h26: e.res = rs ^ rt;
               6'h27: e.res = ~(rs | rt);
               6'h2A: e.res = (srs < srt) ? 32'd1 : 32'd0;
               6'h2B: e.res = (rs < rt) ? 32'd1 : 32'd0;
               default: arith = 1'b0;
            endcase
            if (arith) begin
               e.w = 1'b1; e.wa = 2'd0; e.src = 2'd3; e.chk_wa = 1'b1; e.chk_res = 1'b1;
            end
         end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
            e.w = 1'b1; e.wa = 2'd1; e.src = 2'd3; e.chk_wa = 1'b1; e.chk_res = 1'b1;
            case (op)
               6'h0A:   e.res = (srs < ssimm) ? 32'd1 : 32'd0;
               6'h0B:   e.res = (rs < simm) ? 32'd1 : 32'd0;
               6'h0C:   e.res = rs & zimm;
               6'h0D:   e.res = rs | zimm;
               6'h0E:   e.res = rs ^ zimm;
               6'h0F:   e.res = {ins[15:0], 16'd0};
               default: e.res = rs + simm;
            endcase
         end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
            e.w = 1'b1; e.wa = 2'd1; e.src = 2'd2; e.chk_wa = 1'b1; e.chk_res = 1'b1;
            e.res = rs + simm; e.chk_ul = 1'b1;
            e.ul = (op == 6'h24) || (op == 6'h25);
            e.rm = (op == 6'h20 || op == 6'h24) ? 3'd1 : (op == 6'h23) ? 3'd3 : 3'd2;
         end
         6'h28, 6'h29, 6'h2B: begin
            e.res = rs + simm; e.chk_res = 1'b1;
            e.wm = (op == 6'h28) ? 3'd1 : (op == 6'h29) ? 3'd2 : 3'd3;
         end
         6'h04, 6'h05, 6'h06, 6'h07, 6'h01: begin
            e.tgt = pc4 + (simm << 2);
            e.res = (op == 6'h04 || op == 6'h05) ? rs - rt : rs;
            e.chk_res = (op != 6'h01) || (ins[20:16] < 5'd2);
            case (op)
               6'h04: e.take = (rs == rt);
               6'h05: e.take = (rs != rt);
               6'h06: e.take = (srs <= 0);
               6'h07: e.take = (srs > 0);
               default: e.take = (ins[20:16] == 5'd0) ? (srs < 0) :
                                 (ins[20:16] == 5'd1) ? (srs >= 0) : 1'b0;
            endcase
         end
         6'h02, 6'h03: begin
            e.take = 1'b1; e.tgt = {pc4[31:28], ins[25:0], 2'b00};
            if (op == 6'h03) begin e.w = 1'b1; e.wa = 2'd2; e.src = 2'd1; e.chk_wa = 1'b1; end
         end
         default: ;
      endcase
      return e;
   endfunction

   task automatic drive(input logic [31:0] ins, rs, rt, pc);
      @(posedge clk);
      #1;
      bus.instructionData = ins; bus.rsValue = rs; bus.rtValue = rt; bus.pcAddress = pc;
      #2;
      $display("txn instr=%h rs=%h rt=%h pc=%h -> result=%h newpc=%0b to=%h",
               ins, rs, rt, pc, bus.result, bus.shouldUseNewPC, bus.branchTo);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'h7FFFFFFF;
         3: return 32'h80000000;
         4: return 32'hFFFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      drive(i_ins(6'h2B, 5'd1, 5'd2, 16'h0010), 32'h100, 32'h5, 32'h0);
      drive(j_ins(6'h02, 26'h40), 32'h100, 32'h5, 32'h0);
      total++; if (bus.shouldUseNewPC !== 1'b0) begin bad++; $display("FAIL reset_newpc got %0b want 0", bus.shouldUseNewPC); end
      total++; if (bus.branchTo !== 32'h0) begin bad++; $display("FAIL reset_branchto got %h want 0", bus.branchTo); end
      drive(i_ins(6'h2B, 5'd1, 5'd2, 16'h0010), 32'h100, 32'h5, 32'h0);
      total++; if (bus.writeMode !== 3'd0) begin bad++; $display("FAIL reset_wmode got %0d want 0", bus.writeMode); end
      total++; if (bus.readMode !== 3'd0) begin bad++; $display("FAIL reset_rmode got %0d want 0", bus.readMode); end
      total++; if (bus.registerWrite !== 1'b0) begin bad++; $display("FAIL reset_rw got %0b want 0", bus.registerWrite); end
      total++; if (bus.registerRead !== 1'b0) begin bad++; $display("FAIL reset_rr got %0b want 0", bus.registerRead); end
      total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got %h want 0", bus.result); end
      rst = 1'b1;
      drive(i_ins(6'h2B, 5'd1, 5'd2, 16'h0010), 32'h100, 32'h5, 32'h0);
      total++; if (bus.writeMode !== 3'd3) begin bad++; $display("FAIL post_reset_wmode got %0d want 3", bus.writeMode); end
      total++; if (bus.result !== 32'h110) begin bad++; $display("FAIL post_reset_addr got %h want 110", bus.result); end
   endtask

   task automatic test_add_overflow();
      drive(r_ins(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), 32'h7FFFFFFF, 32'h1, 32'h400);
      total++; if (bus.result !== 32'h80000000) begin bad++; $display("FAIL add_ovf result got %h want 80000000", bus.result); end
      total++; if (bus.outputNegative !== 1'b1) begin bad++; $display("FAIL add_ovf neg got %0b want 1", bus.outputNegative); end
      total++; if (bus.outputPositive !== 1'b0) begin bad++; $display("FAIL add_ovf pos got %0b want 0", bus.outputPositive); end
      total++; if (bus.registerWrite !== 1'b1) begin bad++; $display("FAIL add_ovf rw got %0b want 1", bus.registerWrite); end
      total++; if (bus.registerWriteAddressMode !== 2'd0) begin bad++; $display("FAIL add_ovf wa got %0d want 0", bus.registerWriteAddressMode); end
   endtask

   task automatic test_immediates();
      drive(i_ins(6'h08, 5'd4, 5'd5, 16'hFFFF), 32'h5, 32'h0, 32'h0);
      total++; if (bus.result !== 32'h4) begin bad++; $display("FAIL addi result got %h want 4", bus.result); end
      drive(i_ins(6'h0D, 5'd0, 5'd5, 16'hFFFF), 32'h0, 32'h0, 32'h0);
      total++; if (bus.result !== 32'h0000FFFF) begin bad++; $display("FAIL ori result got %h want 0000ffff", bus.result); end
      total++; if (bus.registerWriteAddressMode !== 2'd1) begin bad++; $display("FAIL ori wa got %0d want 1", bus.registerWriteAddressMode); end
   endtask

   task automatic test_branch();
      drive(i_ins(6'h04, 5'd1, 5'd2, 16'hFFFE), 32'h7, 32'h7, 32'h100);
      total++; if (bus.shouldUseNewPC !== 1'b1) begin bad++; $display("FAIL beq_taken got %0b want 1", bus.shouldUseNewPC); end
      total++; if (bus.branchTo !== 32'hFC) begin bad++; $display("FAIL beq_target got %h want fc", bus.branchTo); end
      total++; if (bus.registerWrite !== 1'b0) begin bad++; $display("FAIL beq_rw got %0b want 0", bus.registerWrite); end
      drive(i_ins(6'h04, 5'd1, 5'd2, 16'hFFFE), 32'h7, 32'h8, 32'h100);
      total++; if (bus.shouldUseNewPC !== 1'b0) begin bad++; $display("FAIL beq_not_taken got %0b want 0", bus.shouldUseNewPC); end
   endtask

   task automatic test_jal();
      drive(j_ins(6'h03, 26'h40), 32'h0, 32'h0, 32'h10000000);
      total++; if (bus.branchTo !== 32'h10000100) begin bad++; $display("FAIL jal_target got %h want 10000100", bus.branchTo); end
      total++; if (bus.registerWriteAddressMode !== 2'd2) begin bad++; $display("FAIL jal_wa got %0d want 2", bus.registerWriteAddressMode); end
      total++; if (bus.registerWriteSource !== 2'd1) begin bad++; $display("FAIL jal_src got %0d want 1", bus.registerWriteSource); end
   endtask

   task automatic test_memory();
      drive(i_ins(6'h23, 5'd1, 5'd2, 16'hFFFC), 32'h200, 32'h0, 32'h0);
      total++; if (bus.result !== 32'h1FC) begin bad++; $display("FAIL lw_addr got %h want 1fc", bus.result); end
      total++; if (bus.readMode !== 3'd3) begin bad++; $display("FAIL lw_rmode got %0d want 3", bus.readMode); end
      total++; if (bus.registerWriteSource !== 2'd2) begin bad++; $display("FAIL lw_src got %0d want 2", bus.registerWriteSource); end
      drive(i_ins(6'h28, 5'd1, 5'd2, 16'h0003), 32'h200, 32'h0, 32'h0);
      total++; if (bus.writeMode !== 3'd1) begin bad++; $display("FAIL sb_wmode got %0d want 1", bus.writeMode); end
      total++; if (bus.registerWrite !== 1'b0) begin bad++; $display("FAIL sb_rw got %0b want 0", bus.registerWrite); end
   endtask

   task automatic test_reset_during_sw();
      rst = 1'b0;
      drive(i_ins(6'h2B, 5'd1, 5'd2, 16'h0000), 32'h40, 32'h0, 32'h0);
      drive(i_ins(6'h2B, 5'd1, 5'd2, 16'h0000), 32'h40, 32'h0, 32'h0);
      total++; if (bus.writeMode !== 3'd0) begin bad++; $display("FAIL midrst_wmode got %0d want 0", bus.writeMode); end
      total++; if (bus.shouldUseNewPC !== 1'b0) begin bad++; $display("FAIL midrst_newpc got %0b want 0", bus.shouldUseNewPC); end
      rst = 1'b1;
      drive(i_ins(6'h2B, 5'd1, 5'd2, 16'h0000), 32'h40, 32'h0, 32'h0);
      total++; if (bus.writeMode !== 3'd3) begin bad++; $display("FAIL midrst_after got %0d want 3", bus.writeMode); end
   endtask

   task automatic test_random_back_to_back(input int n);
      logic [31:0] ins, rs, rt, pc;
      exp_t e;
      for (int i = 0; i < n; i++) begin
         ins = $urandom;
         if ($urandom_range(0, 9) != 0) ins[31:26] = op_list[$urandom_range(0, 23)];
         if (ins[31:26] == 6'h00 && $urandom_range(0, 7) != 0) ins[5:0] = fn_list[$urandom_range(0, 17)];
         if (ins[31:26] == 6'h01) ins[20:16] = 5'($urandom_range(0, 2));
         rs = pick();
         rt = ($urandom_range(0, 3) == 0) ? rs : pick();
         pc = $urandom & 32'hFFFFFFFC;
         e = model(ins, rs, rt, pc);
         drive(ins, rs, rt, pc);
         total++; if (bus.registerWrite !== e.w) begin bad++; $display("FAIL rnd%0d rw instr=%h got %0b want %0b", i, ins, bus.registerWrite, e.w); end
         total++; if (bus.registerWriteSource !== e.src) begin bad++; $display("FAIL rnd%0d src instr=%h got %0d want %0d", i, ins, bus.registerWriteSource, e.src); end
         total++; if (bus.readMode !== e.rm) begin bad++; $display("FAIL rnd%0d rmode instr=%h got %0d want %0d", i, ins, bus.readMode, e.rm); end
         total++; if (bus.writeMode !== e.wm) begin bad++; $display("FAIL rnd%0d wmode instr=%h got %0d want %0d", i, ins, bus.writeMode, e.wm); end
         total++; if (bus.shouldUseNewPC !== e.take) begin bad++; $display("FAIL rnd%0d take instr=%h got %0b want %0b", i, ins, bus.shouldUseNewPC, e.take); end
         if (e.take) begin
            total++; if (bus.branchTo !== e.tgt) begin bad++; $display("FAIL rnd%0d target instr=%h got %h want %h", i, ins, bus.branchTo, e.tgt); end
         end
         if (e.chk_wa) begin
            total++; if (bus.registerWriteAddressMode !== e.wa) begin bad++; $display("FAIL rnd%0d wa instr=%h got %0d want %0d", i, ins, bus.registerWriteAddressMode, e.wa); end
         end
         if (e.chk_ul) begin
            total++; if (bus.unsignedLoad !== e.ul) begin bad++; $display("FAIL rnd%0d uload instr=%h got %0b want %0b", i, ins, bus.unsignedLoad, e.ul); end
         end
         if (e.chk_res) begin
            total++; if (bus.result !== e.res) begin bad++; $display("FAIL rnd%0d result instr=%h got %h want %h", i, ins, bus.result, e.res); end
            total++; if (bus.outputZero !== (e.res == 32'd0)) begin bad++; $display("FAIL rnd%0d zero instr=%h got %0b res %h", i, ins, bus.outputZero, e.res); end
            total++; if (bus.outputNegative !== e.res[31]) begin bad++; $display("FAIL rnd%0d neg instr=%h got %0b res %h", i, ins, bus.outputNegative, e.res); end
            total++; if (bus.outputPositive !== ($signed(e.res) > 0)) begin bad++; $display("FAIL rnd%0d pos instr=%h got %0b res %h", i, ins, bus.outputPositive, e.res); end
         end
      end
   endtask

   initial begin
      bus.instructionData = '0; bus.rsValue = '0; bus.rtValue = '0; bus.pcAddress = '0;
      test_reset();
      test_add_overflow();
      test_immediates();
      test_branch();
      test_jal();
      test_memory();
      test_reset_during_sw();
      test_random_back_to_back(400);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
